// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller: aligns and issues one memory access at a time,
// holds the request until acknowledged and returns right-justified load data.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [2:0]  load_sel,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam bit             TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic is_byte, is_half, misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [2:0]  req_sel;

  // Illegal encodings fall through to word size, so they get word alignment rules.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (req_we) begin
      is_byte = (req_funct3 == 3'b000);
      is_half = (req_funct3 == 3'b001);
    end else begin
      is_byte = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
      is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    end
    misaligned = (is_half && req_addr[0]) ||
                 (!is_byte && !is_half && (req_addr[1:0] != 2'b00));

    req_be = 4'b1111;
    req_wd = req_wdata;
    if (req_we && is_byte) begin
      req_be = 4'b0001 << req_addr[1:0];
      req_wd = {4{req_wdata[7:0]}};
    end else if (req_we && is_half) begin
      req_be = 4'b0011 << req_addr[1:0];
      req_wd = {2{req_wdata[15:0]}};
    end

    unique case (req_funct3)
      3'b000:  req_sel = 3'b000;
      3'b001:  req_sel = 3'b001;
      3'b100:  req_sel = 3'b011;
      3'b101:  req_sel = 3'b100;
      default: req_sel = 3'b010;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    err_addr_d   = err_addr_q;
    stall        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned) begin
            misalign_d = 1'b1;
            err_addr_d = req_addr;
          end else begin
            stall   = 1'b1;
            addr_d  = req_addr;
            we_d    = req_we;
            be_d    = req_be;
            wdata_d = req_wd;
            sel_d   = req_sel;
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (!we_q) load_data_d = mem_rdata >> {addr_q[1:0], 3'b000};
          load_valid_d = !we_q;
          state_d      = StDone;
        end else if (TimeoutEn && (cnt_q == CntMax)) begin
          bus_err_d  = 1'b1;
          err_addr_d = addr_q;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign mem_req      = (state_q == StWait);
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign load_sel     = sel_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed spec cases plus random ops against a size/offset
// arithmetic model; a second instance with a short timeout covers bus_err.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, mem_ack;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic        stall, mem_req, mem_we, load_valid, misalign_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, load_data, err_addr;
  logic [3:0]  mem_be;
  logic [2:0]  load_sel;

  logic        to_stall, to_mem_req, to_mem_we, to_load_valid, to_misalign_err, to_bus_err;
  logic [31:0] to_mem_addr, to_mem_wdata, to_load_data, to_err_addr;
  logic [3:0]  to_mem_be;
  logic [2:0]  to_load_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_valid(load_valid), .load_data(load_data),
    .load_sel(load_sel), .misalign_err(misalign_err), .bus_err(bus_err), .err_addr(err_addr)
  );

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(to_stall), .mem_req(to_mem_req),
    .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_be(to_mem_be),
    .mem_wdata(to_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load_valid(to_load_valid), .load_data(to_load_data), .load_sel(to_load_sel),
    .misalign_err(to_misalign_err), .bus_err(to_bus_err), .err_addr(to_err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the op type and funct3.
  function automatic int op_size(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                        input bit hold_in_done);
    int          sz, off;
    bit          ok;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld;
    logic [2:0]  sel_tab [8];
    sel_tab = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd2, 3'd2};
    sz  = op_size(we, f3);
    off = int'(addr[1:0]);
    ok  = (off % sz) == 0;
    exp_be = we ? 4'((((1 << sz) - 1) << off)) : 4'hf;
    exp_wd = (sz == 1) ? {24'd0, wdata[7:0]} * 32'h01010101 :
             (sz == 2) ? {16'd0, wdata[15:0]} * 32'h00010001 : wdata;
    exp_ld = rdata >> (8 * off);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'b0;
    #1 chk("accept_stall", {31'd0, stall}, {31'd0, ok});
    @(negedge clk);
    req_valid = 1'b0;
    if (!ok) begin
      #1;
      chk("misalign_err", {31'd0, misalign_err}, 32'd1);
      chk("misalign_addr", err_addr, addr);
      chk("misalign_noreq", {31'd0, mem_req}, 32'd0);
      chk("misalign_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1 chk("misalign_pulse", {31'd0, misalign_err}, 32'd0);
      return;
    end
    for (int k = 0; k <= delay; k++) begin
      if (k == delay) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      #1;
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_addr", mem_addr, {addr[31:2], 2'b00});
      chk("wait_be", {28'd0, mem_be}, {28'd0, exp_be});
      chk("wait_we", {31'd0, mem_we}, {31'd0, we});
      if (we) chk("wait_wdata", mem_wdata, exp_wd);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (hold_in_done) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    end
    #1;
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, mem_req}, 32'd0);
    chk("done_lvalid", {31'd0, load_valid}, {31'd0, !we});
    if (!we) begin
      chk("load_data", load_data, exp_ld);
      chk("load_sel", {29'd0, load_sel}, {29'd0, sel_tab[f3]});
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    chk("idle_lvalid", {31'd0, load_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    do_reset();
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_lvalid", {31'd0, load_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    chk("rst_erraddr", err_addr, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);

    // Directed cases from the block description
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    chk("lw_data_const", load_data, 32'hDEADBEEF);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233, 1'b0);
    chk("lbu_data_const", load_data, 32'h00000080);
    run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'b000, 32'h10, 32'hA5A5A5C3, 5, 32'h0, 1'b0);
    run_op(1'b0, 3'b011, 32'h102, 32'h0, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b101, 32'h206, 32'h0, 2, 32'hCAFEF00D, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {$urandom_range(0, 32'hFFFF), 16'd0} | 32'($urandom_range(0, 255)),
             $urandom, $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)));
    end

    // Timeout on the short-timeout instance; the default instance stays in WAIT.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    #1 chk("to_accept_stall", {31'd0, to_stall}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_wait_req", {31'd0, to_mem_req}, 32'd1);
      chk("to_wait_buserr", {31'd0, to_bus_err}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("to_buserr", {31'd0, to_bus_err}, 32'd1);
    chk("to_erraddr", to_err_addr, 32'h40);
    chk("to_lvalid", {31'd0, to_load_valid}, 32'd0);
    chk("to_req_drop", {31'd0, to_mem_req}, 32'd0);
    chk("to_stall_done", {31'd0, to_stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("to_buserr_pulse", {31'd0, to_bus_err}, 32'd0);
    chk("to_idle_stall", {31'd0, to_stall}, 32'd0);
    chk("main_still_wait", {31'd0, mem_req}, 32'd1);

    // Reset during WAIT, then a late ack
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("rstwait_req", {31'd0, mem_req}, 32'd0);
    chk("rstwait_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_lvalid", {31'd0, load_valid}, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
